// File: rtl/riscv_pkg.sv
// Shared RV32I execute-stage constants: ALU opcodes, branch funct3 codes,
// forwarding selects and fixed field widths.
package riscv_pkg;

  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned FUNCT3_W   = 3;
  localparam int unsigned FWD_W      = 2;
  localparam int unsigned RES_SRC_W  = 2;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned SHAMT_W    = 5;

  // ALU opcodes
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL   = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT   = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU  = 4'b0100;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR   = 4'b0101;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL   = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA   = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR    = 4'b1000;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND   = 4'b1001;
  localparam logic [ALU_CTRL_W-1:0] ALU_PASSB = 4'b1010;

  // Branch conditions (funct3); 010/011 are never taken
  localparam logic [FUNCT3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [FUNCT3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [FUNCT3_W-1:0] F3_BGEU = 3'b111;

  // Forwarding selects; 2'b11 behaves like FWD_REG
  localparam logic [FWD_W-1:0] FWD_REG = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/execute_cycle_if.sv
// Execute-stage bus: ID/EX controls and operands in, fetch redirect and
// EX/MEM register contents out.
//   master: upstream/downstream pipeline side (drives E, hazard and W inputs)
//   slave : the execute stage
interface execute_cycle_if
  import riscv_pkg::*;
#(
  parameter int unsigned PC_W = 13,
  parameter int unsigned XLEN = 32
);

  logic                  RegWriteE;
  logic                  MemWriteE;
  logic                  BrE;
  logic                  JumpE;
  logic                  JalrE;
  logic                  op_a_sel_E;
  logic                  op_b_sel_E;
  logic [ALU_CTRL_W-1:0] ALUControlE;
  logic [FUNCT3_W-1:0]   funct3_E;
  logic [RES_SRC_W-1:0]  ResultSrcE;
  logic [XLEN-1:0]       rs1_E;
  logic [XLEN-1:0]       rs2_E;
  logic [XLEN-1:0]       immOut_E;
  logic [REG_ADDR_W-1:0] rd_addr_E;
  logic [PC_W-1:0]       PCE;
  logic [PC_W-1:0]       PCPlus4E;
  logic [FWD_W-1:0]      ForwardAE;
  logic [FWD_W-1:0]      ForwardBE;
  logic [XLEN-1:0]       ResultW;

  logic                  PCSrcE;
  logic [PC_W-1:0]       PCTargetE;
  logic                  RegWriteM;
  logic                  MemWriteM;
  logic [RES_SRC_W-1:0]  ResultSrcM;
  logic [XLEN-1:0]       ALUResultM;
  logic [XLEN-1:0]       WriteDataM;
  logic [REG_ADDR_W-1:0] rd_addr_M;
  logic [PC_W-1:0]       PCPlus4M;

  modport master (
    output RegWriteE, MemWriteE, BrE, JumpE, JalrE, op_a_sel_E, op_b_sel_E,
           ALUControlE, funct3_E, ResultSrcE, rs1_E, rs2_E, immOut_E,
           rd_addr_E, PCE, PCPlus4E, ForwardAE, ForwardBE, ResultW,
    input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, ALUResultM,
           WriteDataM, rd_addr_M, PCPlus4M
  );

  modport slave (
    input  RegWriteE, MemWriteE, BrE, JumpE, JalrE, op_a_sel_E, op_b_sel_E,
           ALUControlE, funct3_E, ResultSrcE, rs1_E, rs2_E, immOut_E,
           rd_addr_E, PCE, PCPlus4E, ForwardAE, ForwardBE, ResultW,
    output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, ALUResultM,
           WriteDataM, rd_addr_M, PCPlus4M
  );

endinterface

// File: rtl/alu.sv
// Combinational RV32I ALU, results mod 2^XLEN, no flags.
//   SrcA, SrcB : operands
//   ALUControl : opcode (riscv_pkg ALU_*); undefined codes yield 0
//   result     : ALU output
module alu
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]       SrcA,
  input  logic [XLEN-1:0]       SrcB,
  input  logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [XLEN-1:0]       result
);

  logic [SHAMT_W-1:0] shamt;

  assign shamt = SrcB[SHAMT_W-1:0];

  always_comb begin
    result = '0;
    unique case (ALUControl)
      ALU_ADD:   result = SrcA + SrcB;
      ALU_SUB:   result = SrcA - SrcB;
      ALU_SLL:   result = SrcA << shamt;
      ALU_SRL:   result = SrcA >> shamt;
      ALU_SRA:   result = XLEN'($signed(SrcA) >>> shamt);
      ALU_SLT:   result = XLEN'($signed(SrcA) < $signed(SrcB));
      ALU_SLTU:  result = XLEN'(SrcA < SrcB);
      ALU_XOR:   result = SrcA ^ SrcB;
      ALU_OR:    result = SrcA | SrcB;
      ALU_AND:   result = SrcA & SrcB;
      ALU_PASSB: result = SrcB;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/execute_cycle.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution with a
// combinational fetch redirect, and the EX/MEM pipeline register.
//   clk : clock, all state on posedge
//   rst : asynchronous active-low reset, clears the EX/MEM register
//   bus : execute_cycle_if.slave (ID/EX inputs, forwarding, redirect, M outputs)
module execute_cycle
  import riscv_pkg::*;
#(
  parameter int unsigned PC_W = 13,
  parameter int unsigned XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  execute_cycle_if.slave        bus
);

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic [PC_W-1:0] jalr_sum;
  logic [PC_W-1:0] branch_target;
  logic            cond_true;

  // Forwarding muxes; FWD_MEM reads our own EX/MEM register
  always_comb begin
    fwd_a = bus.rs1_E;
    unique case (bus.ForwardAE)
      FWD_REG: fwd_a = bus.rs1_E;
      FWD_WB:  fwd_a = bus.ResultW;
      FWD_MEM: fwd_a = bus.ALUResultM;
      default: fwd_a = bus.rs1_E;
    endcase
  end

  always_comb begin
    fwd_b = bus.rs2_E;
    unique case (bus.ForwardBE)
      FWD_REG: fwd_b = bus.rs2_E;
      FWD_WB:  fwd_b = bus.ResultW;
      FWD_MEM: fwd_b = bus.ALUResultM;
      default: fwd_b = bus.rs2_E;
    endcase
  end

  assign src_a = bus.op_a_sel_E ? XLEN'(bus.PCE) : fwd_a;
  assign src_b = bus.op_b_sel_E ? bus.immOut_E : fwd_b;

  alu #(.XLEN(XLEN)) u_alu (
    .SrcA       (src_a),
    .SrcB       (src_b),
    .ALUControl (bus.ALUControlE),
    .result     (alu_result)
  );

  // Branch condition on forwarded register values, never on the immediate
  always_comb begin
    cond_true = 1'b0;
    unique case (bus.funct3_E)
      F3_BEQ:  cond_true = (fwd_a == fwd_b);
      F3_BNE:  cond_true = (fwd_a != fwd_b);
      F3_BLT:  cond_true = ($signed(fwd_a) <  $signed(fwd_b));
      F3_BGE:  cond_true = ($signed(fwd_a) >= $signed(fwd_b));
      F3_BLTU: cond_true = (fwd_a <  fwd_b);
      F3_BGEU: cond_true = (fwd_a >= fwd_b);
      default: cond_true = 1'b0;
    endcase
  end

  // Targets only need PC_W bits, so the adders are truncated up front
  assign jalr_sum      = fwd_a[PC_W-1:0] + bus.immOut_E[PC_W-1:0];
  assign branch_target = bus.PCE + bus.immOut_E[PC_W-1:0];

  assign bus.PCSrcE    = bus.JumpE | (bus.BrE & cond_true);
  assign bus.PCTargetE = (bus.JumpE & bus.JalrE) ? (jalr_sum & ~PC_W'(1))
                                                 : branch_target;

  // EX/MEM register, loads unconditionally every cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.RegWriteM  <= 1'b0;
      bus.MemWriteM  <= 1'b0;
      bus.ResultSrcM <= '0;
      bus.ALUResultM <= '0;
      bus.WriteDataM <= '0;
      bus.rd_addr_M  <= '0;
      bus.PCPlus4M   <= '0;
    end else begin
      bus.RegWriteM  <= bus.RegWriteE;
      bus.MemWriteM  <= bus.MemWriteE;
      bus.ResultSrcM <= bus.ResultSrcE;
      bus.ALUResultM <= alu_result;
      bus.WriteDataM <= fwd_b;
      bus.rd_addr_M  <= bus.rd_addr_E;
      bus.PCPlus4M   <= bus.PCPlus4E;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed vector table, randomized
// stimulus against a behavioural model, and asynchronous reset sequences.
module tb_execute_cycle;
  import riscv_pkg::*;

  typedef struct {
    logic        reg_write;
    logic        mem_write;
    logic        br;
    logic        jump;
    logic        jalr;
    logic        op_a_sel;
    logic        op_b_sel;
    logic [3:0]  alu_ctrl;
    logic [2:0]  funct3;
    logic [1:0]  result_src;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [12:0] pc;
    logic [12:0] pc4;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] result_w;
  } in_t;

  typedef struct {
    in_t         i;
    logic        pcsrc;
    logic [12:0] target;
    logic [31:0] alu;
    logic [31:0] wd;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t vq[$];
  logic [31:0] model_alu_m;

  execute_cycle_if #(.PC_W(13), .XLEN(32)) bus ();

  execute_cycle #(.PC_W(13), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic in_t zero_in();
    in_t t;
    t = '{default: '0};
    return t;
  endfunction

  task automatic drive(input in_t t);
    bus.RegWriteE   = t.reg_write;
    bus.MemWriteE   = t.mem_write;
    bus.BrE         = t.br;
    bus.JumpE       = t.jump;
    bus.JalrE       = t.jalr;
    bus.op_a_sel_E  = t.op_a_sel;
    bus.op_b_sel_E  = t.op_b_sel;
    bus.ALUControlE = t.alu_ctrl;
    bus.funct3_E    = t.funct3;
    bus.ResultSrcE  = t.result_src;
    bus.rs1_E       = t.rs1;
    bus.rs2_E       = t.rs2;
    bus.immOut_E    = t.imm;
    bus.rd_addr_E   = t.rd;
    bus.PCE         = t.pc;
    bus.PCPlus4E    = t.pc4;
    bus.ForwardAE   = t.fwd_a;
    bus.ForwardBE   = t.fwd_b;
    bus.ResultW     = t.result_w;
  endtask

  task automatic add_vec(input in_t t, input logic pcsrc, input logic [12:0] tgt,
                         input logic [31:0] alu_v, input logic [31:0] wd);
    vec_t v;
    if (t.rd == 5'd0) t.rd = 5'(vq.size() + 1);
    if (t.pc4 == 13'd0) t.pc4 = 13'(32'h0400 + 4 * vq.size());
    v.i = t; v.pcsrc = pcsrc; v.target = tgt; v.alu = alu_v; v.wd = wd;
    vq.push_back(v);
  endtask

  task automatic check_m_zero(input string tag);
    chk({tag, ".RegWriteM"},  32'(bus.RegWriteM),  32'd0);
    chk({tag, ".MemWriteM"},  32'(bus.MemWriteM),  32'd0);
    chk({tag, ".ResultSrcM"}, 32'(bus.ResultSrcM), 32'd0);
    chk({tag, ".ALUResultM"}, bus.ALUResultM,      32'd0);
    chk({tag, ".WriteDataM"}, bus.WriteDataM,      32'd0);
    chk({tag, ".rd_addr_M"},  32'(bus.rd_addr_M),  32'd0);
    chk({tag, ".PCPlus4M"},   32'(bus.PCPlus4M),   32'd0);
  endtask

  task automatic check_passthru(input string tag, input in_t t);
    chk({tag, ".RegWriteM"},  32'(bus.RegWriteM),  32'(t.reg_write));
    chk({tag, ".MemWriteM"},  32'(bus.MemWriteM),  32'(t.mem_write));
    chk({tag, ".ResultSrcM"}, 32'(bus.ResultSrcM), 32'(t.result_src));
    chk({tag, ".rd_addr_M"},  32'(bus.rd_addr_M),  32'(t.rd));
    chk({tag, ".PCPlus4M"},   32'(bus.PCPlus4M),   32'(t.pc4));
  endtask

  // ---- behavioural reference model ----
  localparam logic [31:0] SIGN = 32'h8000_0000;

  function automatic logic [31:0] m_fwd(input logic [1:0] s, input logic [31:0] r,
                                        input logic [31:0] w, input logic [31:0] m);
    if (s == 2'd1) return w;
    if (s == 2'd2) return m;
    return r;
  endfunction

  function automatic logic [31:0] m_alu(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    int unsigned sh;
    logic [31:0] all1;
    sh = 32'(b[4:0]);
    all1 = 32'hFFFF_FFFF;
    case (c)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return (a >> sh) | (a[31] ? ~(all1 >> sh) : 32'd0);
      4'd3:  return ((a ^ SIGN) < (b ^ SIGN)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_taken(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
    logic slt;
    logic ult;
    slt = (a ^ SIGN) < (b ^ SIGN);
    ult = a < b;
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return slt;
      3'd5: return !slt;
      3'd6: return ult;
      3'd7: return !ult;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    in_t t;
    n_checks = 0;
    n_fail = 0;
    model_alu_m = 32'd0;

    // ---- power-on reset ----
    rst = 1'b0;
    drive(zero_in());
    repeat (2) @(posedge clk);
    #1 check_m_zero("por");
    @(negedge clk) rst = 1'b1;

    // ---- directed vector table ----
    t = zero_in(); t.reg_write = 1; t.alu_ctrl = ALU_ADD; t.rs1 = 5; t.rs2 = 7;
    add_vec(t, 1'b0, 13'h0, 32'd12, 32'd7);
    t = zero_in(); t.reg_write = 1; t.alu_ctrl = ALU_ADD; t.rs1 = 99; t.rs2 = 3;
    t.fwd_a = FWD_MEM;
    add_vec(t, 1'b0, 13'h0, 32'd15, 32'd3);
    t = zero_in(); t.reg_write = 1; t.alu_ctrl = ALU_SRA; t.rs1 = 32'h8000_0000;
    t.op_b_sel = 1; t.imm = 4;
    add_vec(t, 1'b0, 13'h4, 32'hF800_0000, 32'd0);
    t = zero_in(); t.reg_write = 1; t.alu_ctrl = ALU_SLT; t.rs1 = 32'hFFFF_FFFF; t.rs2 = 1;
    add_vec(t, 1'b0, 13'h0, 32'd1, 32'd1);
    t.alu_ctrl = ALU_SLTU;
    add_vec(t, 1'b0, 13'h0, 32'd0, 32'd1);
    t = zero_in(); t.br = 1; t.funct3 = F3_BLT; t.rs1 = 32'hFFFF_FFFE; t.rs2 = 1;
    t.pc = 13'h0100; t.imm = 32'hFFFF_FFF8; t.alu_ctrl = ALU_ADD;
    add_vec(t, 1'b1, 13'h00F8, 32'hFFFF_FFFF, 32'd1);
    t.funct3 = F3_BLTU;
    add_vec(t, 1'b0, 13'h00F8, 32'hFFFF_FFFF, 32'd1);
    t = zero_in(); t.reg_write = 1; t.jump = 1; t.jalr = 1; t.fwd_a = FWD_WB;
    t.result_w = 32'h0000_1235; t.imm = 4; t.op_b_sel = 1; t.alu_ctrl = ALU_ADD;
    t.pc4 = 13'h0ABC; t.result_src = 2'd2;
    add_vec(t, 1'b1, 13'h1238, 32'h0000_1239, 32'd0);
    t = zero_in(); t.mem_write = 1; t.op_b_sel = 1; t.imm = 8; t.fwd_b = FWD_WB;
    t.result_w = 32'hDEAD_BEEF; t.rs1 = 32'h100; t.alu_ctrl = ALU_ADD;
    add_vec(t, 1'b0, 13'h8, 32'h108, 32'hDEAD_BEEF);
    t = zero_in(); t.reg_write = 1; t.alu_ctrl = ALU_PASSB; t.op_b_sel = 1;
    t.imm = 32'h1234_5000; t.result_src = 2'd1;
    add_vec(t, 1'b0, 13'h1000, 32'h1234_5000, 32'd0);
    t = zero_in(); t.alu_ctrl = 4'b1111; t.rs1 = 3; t.rs2 = 4;
    add_vec(t, 1'b0, 13'h0, 32'd0, 32'd4);
    t = zero_in(); t.br = 1; t.funct3 = 3'b010; t.rs1 = 5; t.rs2 = 5; t.alu_ctrl = ALU_ADD;
    add_vec(t, 1'b0, 13'h0, 32'd10, 32'd5);
    t = zero_in(); t.br = 1; t.funct3 = F3_BEQ; t.rs1 = 7; t.rs2 = 7; t.alu_ctrl = ALU_ADD;
    t.pc = 13'h0040; t.imm = 32'h10;
    add_vec(t, 1'b1, 13'h0050, 32'd14, 32'd7);
    t = zero_in(); t.reg_write = 1; t.jump = 1; t.pc = 13'h1FF0; t.imm = 32'h20;
    t.result_src = 2'd2;
    add_vec(t, 1'b1, 13'h0010, 32'd0, 32'd0);
    t = zero_in(); t.reg_write = 1; t.alu_ctrl = ALU_SUB; t.fwd_a = 2'b11; t.fwd_b = 2'b11;
    t.rs1 = 10; t.rs2 = 20; t.result_w = 999;
    add_vec(t, 1'b0, 13'h0, 32'hFFFF_FFF6, 32'd20);

    foreach (vq[k]) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      @(negedge clk);
      drive(vq[k].i);
      #1;
      chk({tag, ".PCSrcE"},    32'(bus.PCSrcE),    32'(vq[k].pcsrc));
      chk({tag, ".PCTargetE"}, 32'(bus.PCTargetE), 32'(vq[k].target));
      @(posedge clk);
      #1;
      chk({tag, ".ALUResultM"}, bus.ALUResultM, vq[k].alu);
      chk({tag, ".WriteDataM"}, bus.WriteDataM, vq[k].wd);
      check_passthru(tag, vq[k].i);
      model_alu_m = vq[k].alu;
    end

    // ---- randomized stimulus against the model ----
    for (int n = 0; n < 300; n++) begin
      logic [31:0] fa;
      logic [31:0] fb;
      logic [31:0] sa;
      logic [31:0] sb;
      logic [31:0] e_alu;
      logic        e_src;
      logic [12:0] e_tgt;
      string       tag;
      tag = $sformatf("rnd%0d", n);
      t.reg_write  = 1'($urandom);
      t.mem_write  = 1'($urandom);
      t.br         = 1'($urandom);
      t.jump       = ($urandom_range(0, 3) == 0);
      t.jalr       = 1'($urandom);
      t.op_a_sel   = 1'($urandom);
      t.op_b_sel   = 1'($urandom);
      t.alu_ctrl   = 4'($urandom);
      t.funct3     = 3'($urandom);
      t.result_src = 2'($urandom);
      t.rs1        = $urandom;
      t.rs2        = ($urandom_range(0, 4) == 0) ? t.rs1 : $urandom;
      t.imm        = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
      t.rd         = 5'($urandom);
      t.pc         = 13'($urandom);
      t.pc4        = 13'($urandom);
      t.fwd_a      = 2'($urandom);
      t.fwd_b      = 2'($urandom);
      t.result_w   = $urandom;

      fa = m_fwd(t.fwd_a, t.rs1, t.result_w, model_alu_m);
      fb = m_fwd(t.fwd_b, t.rs2, t.result_w, model_alu_m);
      sa = t.op_a_sel ? {19'd0, t.pc} : fa;
      sb = t.op_b_sel ? t.imm : fb;
      e_alu = m_alu(t.alu_ctrl, sa, sb);
      e_src = t.jump | (t.br & m_taken(t.funct3, fa, fb));
      e_tgt = (t.jump & t.jalr) ? 13'((fa + t.imm) & 32'hFFFF_FFFE)
                                : 13'({19'd0, t.pc} + t.imm);

      @(negedge clk);
      drive(t);
      #1;
      chk({tag, ".PCSrcE"},    32'(bus.PCSrcE),    32'(e_src));
      chk({tag, ".PCTargetE"}, 32'(bus.PCTargetE), 32'(e_tgt));
      @(posedge clk);
      #1;
      chk({tag, ".ALUResultM"}, bus.ALUResultM, e_alu);
      chk({tag, ".WriteDataM"}, bus.WriteDataM, fb);
      check_passthru(tag, t);
      model_alu_m = e_alu;
    end

    // ---- asynchronous reset mid-operation ----
    @(negedge clk);
    t = '{reg_write: 1, mem_write: 1, br: 0, jump: 1, jalr: 0, op_a_sel: 0,
          op_b_sel: 0, alu_ctrl: ALU_ADD, funct3: 3'b111, result_src: 2'd3,
          rs1: 32'd1, rs2: 32'd2, imm: 32'h40, rd: 5'd31, pc: 13'h0200,
          pc4: 13'h1FFF, fwd_a: 2'd0, fwd_b: 2'd0, result_w: 32'h55};
    drive(t);
    @(posedge clk);
    #1 chk("arst.pre.ALUResultM", bus.ALUResultM, 32'd3);
    #2 rst = 1'b0;
    #1;
    check_m_zero("arst.now");
    chk("arst.PCSrcE",    32'(bus.PCSrcE),    32'd1);
    chk("arst.PCTargetE", 32'(bus.PCTargetE), 32'h0240);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 check_m_zero($sformatf("arst.hold%0d", c));
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk("arst.post.ALUResultM", bus.ALUResultM, 32'd3);
    chk("arst.post.WriteDataM", bus.WriteDataM, 32'd2);
    check_passthru("arst.post", t);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
- Execute stage of the 5-stage RV32I pipeline. It sits directly downstream of the ID/EX register and consumes its outputs.
- Applies operand forwarding, runs the ALU and resolves branches and jumps.
- Returns redirect information to fetch combinationally.
- Holds the EX/MEM pipeline register that feeds the memory stage.

Parameters:
- PC_W, 13, width of PC and PC+4 fields.
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- RegWriteE, MemWriteE, BrE, JumpE  in  1 each  control from ID/EX.
- JalrE  in  1  jump is JALR; otherwise JAL.
- op_a_sel_E  in  1  0: operand A = rs1, 1: operand A = PCE zero-extended.
- op_b_sel_E  in  1  0: operand B = rs2, 1: operand B = immOut_E.
- ALUControlE  in  4  ALU opcode.
- funct3_E  in  3  branch condition.
- ResultSrcE  in  2  writeback select, passed through.
- rs1_E, rs2_E, immOut_E  in  XLEN  register operands and immediate.
- rd_addr_E  in  5  destination register.
- PCE, PCPlus4E  in  PC_W.
- ForwardAE, ForwardBE  in  2  from hazard unit.
- ResultW  in  XLEN  writeback-stage result, forwarding source.
- PCSrcE  out  1  redirect fetch; combinational.
- PCTargetE  out  PC_W  redirect target; combinational.
- RegWriteM, MemWriteM  out  1  registered.
- ResultSrcM  out  2  registered.
- ALUResultM, WriteDataM  out  XLEN  registered.
- rd_addr_M  out  5  registered.
- PCPlus4M  out  PC_W  registered.

Behaviour:
- Forward mux A/B:
  - 00 → rs1_E / rs2_E.
  - 01 → ResultW.
  - 10 → ALUResultM, the internal EX/MEM value.
  - 11 → treated as 00.
- SrcA = op_a_sel_E ? {zero-ext PCE} : fwdA. SrcB = op_b_sel_E ? immOut_E : fwdB.
- ALU ops, mod 2^32, no flags:
  - ADD 0000, SUB 0001.
  - SLL 0010, SRL 0110, SRA 0111; shift amount = SrcB[4:0].
  - SLT 0011 (signed), SLTU 0100; result is 1 or 0.
  - XOR 0101, OR 1000, AND 1001.
  - PASSB 1010 (LUI).
  - Undefined codes give 0.
- Branch compare always uses fwdA vs fwdB, never the muxed SrcB.
  - funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
  - 010 and 011 never taken.
- PCSrcE = JumpE | (BrE & cond_true).
- PCTargetE:
  - JumpE & JalrE: (fwdA + immOut_E) with bit0 cleared, truncated to PC_W.
  - Otherwise: PCE + immOut_E[PC_W-1:0], wrap-around mod 2^PC_W.
- PCSrcE and PCTargetE are combinational, with zero cycles of latency. Flushing IF/ID and ID/EX on redirect is the hazard unit's job, not this block's.
- EX/MEM register: loads every posedge, with no stall or enable.
  - ALUResultM ← ALU result.
  - WriteDataM ← fwdB (pre-immediate mux).
  - RegWriteM, MemWriteM, ResultSrcM, rd_addr_M, PCPlus4M ← their E counterparts.
  - Instruction-to-M latency is 1 cycle.
- Reset (rst=0, asynchronous): every registered output clears to 0 immediately, regardless of clk. The first valid capture is the first posedge after rst deasserts.
  - Reset mid-operation drops the in-flight EX/MEM contents.
  - The combinational outputs follow their inputs during reset.
- Back-to-back dependence: with ForwardAE=10, the instruction in EX sees the ALUResultM captured on the previous edge. No bubble is needed for ALU→ALU.
- JAL/JALR writeback value is PCPlus4M, selected downstream through ResultSrcM. The ALU result for jumps is don't-care.

Decomposition:
- Package riscv_pkg holds:
  - ALU opcode localparams (ALU_ADD … ALU_PASSB).
  - Branch funct3 constants.
  - Forward-select constants FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- One sub-module, alu: purely combinational, inputs SrcA, SrcB, ALUControl, output result.
- Forward muxes, branch compare, target adder and EX/MEM register stay in execute_cycle.

Test Plan:
- Reset: drive all inputs nonzero, pull rst low between edges → all M outputs read 0 before the next posedge and stay 0 through 3 clocks.
- ADD with forwarding:
  - Inputs: rs1_E=5, rs2_E=7, op_b_sel_E=0, ALUControlE=ADD, ForwardAE=00 → ALUResultM=12 after one edge.
  - Next cycle: ForwardAE=10, rs2_E=3 → ALUResultM=15.
- SRA/SLT signed:
  - SRA: SrcA=0x8000_0000, imm=4 → ALUResultM=0xF800_0000.
  - SLT: rs1=0xFFFF_FFFF, rs2=1 → 1; the same operands with SLTU → 0.
- Branches:
  - BrE=1, funct3=100 (BLT), fwdA=-2, fwdB=1, PCE=0x0100, imm=0xFFFF_FFF8 → PCSrcE=1, PCTargetE=0x00F8.
  - Same case with funct3=110 (BLTU) → PCSrcE=0.
- JALR: JumpE=JalrE=1, ForwardAE=01, ResultW=0x0000_1235, imm=4 → PCTargetE=0x1238, PCSrcE=1, PCPlus4M=PCPlus4E after the edge.
- Store data path: MemWriteE=1, op_b_sel_E=1, imm=8, ForwardBE=01, ResultW=0xDEAD_BEEF, rs1_E=0x100 → ALUResultM=0x108, WriteDataM=0xDEAD_BEEF, MemWriteM=1.
